uart_rom_loader: RTL and testbench

- UART boot loader that fills the sc1_cpu instruction RAM over a serial line, then releases the CPU.
- Sits between the board RX pin and the write port of the instruction RAM. It drives the CPU reset while loading, so a program can be downloaded without resynthesis.
- Protocol: 8N1, LSB first. First 4 bytes are a little-endian word count N, followed by N 32-bit instruction words, each little-endian.

---
 rtl/uart_rom_loader.sv | 173 +++++++++++++++++
 tb/tb_uart_rom_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rom_loader.sv
// UART boot loader: receives a word count plus 32-bit words over 8N1 serial,
// writes them into the instruction RAM and holds the CPU in reset until done.
module uart_rom_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH_I      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               uart_rxd,
  output logic               ram_we,
  output logic [DEPTH_I-1:0] ram_addr,
  output logic [31:0]        ram_data,
  output logic               cpu_reset,
  output logic               load_done,
  output logic               frame_error
);

  localparam int             CW      = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [32:0]    CAP     = 33'(1) << DEPTH_I;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_e;
  typedef enum logic [1:0] {L_HDR, L_DATA, L_DONE} ld_st_e;

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  rx_st_e        rx_st_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic [7:0]    rx_byte_q;
  logic          byte_vld_q, ferr_pls_q;

  ld_st_e        ld_st_q;
  logic [1:0]    idx_q;
  logic [31:0]   word_q, word_d;
  logic [31:0]   n_q, wcnt_q;
  logic          ram_we_q, cpu_reset_q, load_done_q, frame_error_q;
  logic [DEPTH_I-1:0] ram_addr_q;
  logic [31:0]   ram_data_q;

  // Bytes arrive LSB first, so shifting right leaves byte k at [8k+7:8k].
  assign word_d = {rx_byte_q, word_q[31:8]};

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rxd;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_st_q    <= R_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      rx_byte_q  <= '0;
      byte_vld_q <= 1'b0;
      ferr_pls_q <= 1'b0;
    end else begin
      byte_vld_q <= 1'b0;
      ferr_pls_q <= 1'b0;
      case (rx_st_q)
        R_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_st_q <= R_START;
            cnt_q   <= '0;
            bit_q   <= '0;
          end
        end
        R_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            rx_st_q <= rx_sync_q ? R_IDLE : R_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        R_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            sh_q  <= {rx_sync_q, sh_q[7:1]};
            bit_q <= bit_q + 3'd1;
            if (bit_q == 3'd7) rx_st_q <= R_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        R_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            rx_st_q <= R_IDLE;
            if (rx_sync_q) begin
              byte_vld_q <= 1'b1;
              rx_byte_q  <= sh_q;
            end else begin
              ferr_pls_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: rx_st_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_st_q       <= L_HDR;
      idx_q         <= '0;
      word_q        <= '0;
      n_q           <= '0;
      wcnt_q        <= '0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_q    <= '0;
      cpu_reset_q   <= 1'b1;
      load_done_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;
      if (ferr_pls_q) frame_error_q <= 1'b1;
      case (ld_st_q)
        L_HDR, L_DATA: begin
          if (ferr_pls_q) begin
            ld_st_q <= L_HDR;
            idx_q   <= '0;
            wcnt_q  <= '0;
          end else if (byte_vld_q) begin
            word_q <= word_d;
            idx_q  <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              if (ld_st_q == L_HDR) begin
                n_q     <= word_d;
                wcnt_q  <= '0;
                ld_st_q <= (word_d == 32'd0) ? L_DONE : L_DATA;
              end else begin
                // Words beyond RAM capacity are consumed but never written.
                if ({1'b0, wcnt_q} < CAP) begin
                  ram_we_q   <= 1'b1;
                  ram_addr_q <= wcnt_q[DEPTH_I-1:0];
                  ram_data_q <= word_d;
                end
                wcnt_q <= wcnt_q + 32'd1;
                if (wcnt_q + 32'd1 == n_q) ld_st_q <= L_DONE;
              end
            end
          end
        end
        L_DONE: begin
          load_done_q <= 1'b1;
          cpu_reset_q <= 1'b0;
        end
        default: ld_st_q <= L_HDR;
      endcase
    end
  end

  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data    = ram_data_q;
  assign cpu_reset   = cpu_reset_q;
  assign load_done   = load_done_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_rom_loader.sv
// Randomized bench for uart_rom_loader: serial streams are driven bit by bit and
// every RAM write is checked against a queue of expected (addr, data) pairs.
module tb_uart_rom_loader;
  localparam int CPB = 8;
  localparam int DI  = 4;
  localparam int CAPW = 1 << DI;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          uart_rxd = 1'b1;
  logic          ram_we;
  logic [DI-1:0] ram_addr;
  logic [31:0]   ram_data;
  logic          cpu_reset, load_done, frame_error;

  uart_rom_loader #(.CLKS_PER_BIT(CPB), .DEPTH_I(DI)) dut (
    .clk(clk), .reset(reset), .uart_rxd(uart_rxd), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_data(ram_data), .cpu_reset(cpu_reset),
    .load_done(load_done), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  int cyc = 0, last_we_cyc = 0;
  bit lat_en = 1'b0;
  logic we_prev = 1'b0, ld_prev = 1'b0;
  logic [35:0] expq[$];
  logic [35:0] e;
  logic [31:0] words[$];
  logic [35:0] last_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Write monitor: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (ram_we) begin
      chk("we_pulse", {63'd0, we_prev}, 64'd0);
      if (expq.size() == 0) chk("unexp_we", {63'd0, ram_we}, 64'd0);
      else begin
        e = expq.pop_front();
        chk("we_addr", {60'd0, ram_addr}, {60'd0, e[35:32]});
        chk("we_data", {32'd0, ram_data}, {32'd0, e[31:0]});
      end
      last_we_cyc = cyc;
    end
    if (load_done && !ld_prev && lat_en) chk("done_lat", 64'(cyc - last_we_cyc), 64'd1);
    if (load_done != ld_prev) chk("cpurst_vs_done", {63'd0, cpu_reset}, {63'd0, ~load_done});
    we_prev = ram_we;
    ld_prev = load_done;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    uart_rxd = 1'b0; wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin uart_rxd = b[i]; wait_cyc(CPB); end
    uart_rxd = stop_ok; wait_cyc(CPB);
    uart_rxd = 1'b1; wait_cyc($urandom_range(0, 3));
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic do_reset();
    uart_rxd = 1'b1;
    reset = 1'b1; wait_cyc(2); reset = 1'b0;
    expq.delete();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_we"},   {63'd0, ram_we}, 64'd0);
    chk({tag, "_addr"}, {60'd0, ram_addr}, 64'd0);
    chk({tag, "_data"}, {32'd0, ram_data}, 64'd0);
    chk({tag, "_cpur"}, {63'd0, cpu_reset}, 64'd1);
    chk({tag, "_done"}, {63'd0, load_done}, 64'd0);
    chk({tag, "_ferr"}, {63'd0, frame_error}, 64'd0);
  endtask

  // Reference: word i lands at addr i while i fits in the RAM; later ones vanish.
  task automatic do_load(input string tag);
    int n;
    n = words.size();
    for (int i = 0; i < n; i++)
      if (i < CAPW) begin
        expq.push_back({4'(i), words[i]});
        last_exp = {4'(i), words[i]};
      end
    lat_en = (n > 0) && (n <= CAPW);
    send_word(32'(n));
    for (int i = 0; i < n; i++) send_word(words[i]);
    wait_cyc(CPB);
    chk({tag, "_left"}, 64'(expq.size()), 64'd0);
    chk({tag, "_done"}, {63'd0, load_done}, 64'd1);
    chk({tag, "_cpur"}, {63'd0, cpu_reset}, 64'd0);
    if (n > 0) begin
      chk({tag, "_hold_addr"}, {60'd0, ram_addr}, {60'd0, last_exp[35:32]});
      chk({tag, "_hold_data"}, {32'd0, ram_data}, {32'd0, last_exp[31:0]});
    end
  endtask

  initial begin
    logic [31:0] w;
    int n;
    do_reset();
    chk_reset_state("rst");

    // basic load
    words = '{32'hDEADBEEF, 32'h00000013};
    do_load("basic");

    // zero-length: done only once the 4th header byte is complete
    do_reset();
    lat_en = 1'b0;
    for (int k = 0; k < 3; k++) send_byte(8'h00, 1'b1);
    uart_rxd = 1'b0; wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin uart_rxd = 1'b0; wait_cyc(CPB); end
    chk("zero_early", {63'd0, load_done}, 64'd0);
    uart_rxd = 1'b1; wait_cyc(2 * CPB);
    chk("zero_done", {63'd0, load_done}, 64'd1);
    chk("zero_cpur", {63'd0, cpu_reset}, 64'd0);

    // glitch mid-header must not count as a byte
    do_reset();
    w = $urandom;
    expq.push_back({4'd0, w});
    lat_en = 1'b1;
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    uart_rxd = 1'b0; wait_cyc(2); uart_rxd = 1'b1; wait_cyc(2 * CPB);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_word(w);
    wait_cyc(CPB);
    chk("glitch_left", 64'(expq.size()), 64'd0);
    chk("glitch_done", {63'd0, load_done}, 64'd1);
    chk("glitch_ferr", {63'd0, frame_error}, 64'd0);

    // bad stop bit during header aborts, then a clean load works
    do_reset();
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b0);
    wait_cyc(CPB);
    chk("ferr_set", {63'd0, frame_error}, 64'd1);
    chk("ferr_cpur", {63'd0, cpu_reset}, 64'd1);
    chk("ferr_done", {63'd0, load_done}, 64'd0);
    words = '{32'h12345678};
    do_load("ferr_reload");
    chk("ferr_sticky", {63'd0, frame_error}, 64'd1);

    // bad stop bit during data: first word stays written, loader restarts
    do_reset();
    w = $urandom;
    expq.push_back({4'd0, w});
    send_word(32'd3); send_word(w);
    send_byte(8'($urandom), 1'b1); send_byte(8'($urandom), 1'b0);
    wait_cyc(CPB);
    chk("dferr_done", {63'd0, load_done}, 64'd0);
    words = '{32'($urandom), 32'($urandom)};
    do_load("dferr_reload");

    // overflow
    do_reset();
    words.delete();
    for (int i = 0; i < 18; i++) words.push_back(32'(i));
    do_load("ovf");

    // reset in the middle of the 3rd byte of word 0
    do_reset();
    send_word(32'd2);
    send_byte(8'($urandom), 1'b1); send_byte(8'($urandom), 1'b1);
    uart_rxd = 1'b0; wait_cyc(CPB);
    for (int i = 0; i < 3; i++) begin uart_rxd = 1'($urandom); wait_cyc(CPB); end
    uart_rxd = 1'b1;
    reset = 1'b1; wait_cyc(1); reset = 1'b0;
    chk_reset_state("midrst");
    wait_cyc(12 * CPB);
    chk("midrst_idle_we", 64'(expq.size()), 64'd0);
    words.delete();
    n = $urandom_range(1, 5);
    for (int i = 0; i < n; i++) words.push_back($urandom);
    do_load("midrst_reload");

    // traffic after DONE is ignored
    for (int k = 0; k < 8; k++) send_byte(8'($urandom), 1'b1);
    wait_cyc(CPB);
    chk("after_done", {63'd0, load_done}, 64'd1);
    chk("after_cpur", {63'd0, cpu_reset}, 64'd0);
    chk("after_left", 64'(expq.size()), 64'd0);

    // random loads
    for (int t = 0; t < 3; t++) begin
      do_reset();
      words.delete();
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) words.push_back($urandom);
      do_load("rand");
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
